// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a power-on init sequence.
//
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write
// data to matching reads while in RUN. Without it, same-cycle reads return
// the pre-write array value.
//
// Ports:
//   clk        single clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   ra / rd    NREAD packed read ports (port i at [i*W +: W])
//   we0/wa0/wd0, we1/wa1/wd1   write ports (port 1 wins on same address)
//   ra_db / rd_db              debug read port
//   init_busy  high while the init sequence walks the array
//
// State | meaning
//   INIT  | cnt walks 0..WORDS-1 writing SP_INIT to SP_INDEX, 0 elsewhere
//   RUN   | normal operation, external writes accepted
module regfile_mp #(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int NREAD      = 2,
  parameter int SP_INDEX   = 2,
  parameter int SP_INIT    = 768
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREAD*BANK_WIDTH-1:0] ra,
  output logic [NREAD*WIDTH-1:0]      rd,
  input  logic                        we0,
  input  logic [BANK_WIDTH-1:0]       wa0,
  input  logic [WIDTH-1:0]            wd0,
  input  logic                        we1,
  input  logic [BANK_WIDTH-1:0]       wa1,
  input  logic [WIDTH-1:0]            wd1,
  input  logic [BANK_WIDTH-1:0]       ra_db,
  output logic [WIDTH-1:0]            rd_db,
  output logic                        init_busy
);

  localparam int WORDS = 2**BANK_WIDTH;

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic [WIDTH-1:0] mem_q [WORDS];

  logic                  state_q, state_d;
  logic [BANK_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_busy_q, init_busy_d;

  // Port 0 path is shared with the init writer; port 1 is external only.
  logic                  wr0_en;
  logic [BANK_WIDTH-1:0] wr0_addr;
  logic [WIDTH-1:0]      wr0_data;
  logic                  wr1_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr0_en   = 1'b0;
    wr0_addr = wa0;
    wr0_data = wd0;
    wr1_en   = 1'b0;
    if (state_q == STATE_INIT) begin
      wr0_en   = 1'b1;
      wr0_addr = cnt_q;
      wr0_data = (cnt_q == BANK_WIDTH'(SP_INDEX)) ? WIDTH'(SP_INIT) : '0;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == BANK_WIDTH'(WORDS - 1)) begin
        state_d = STATE_RUN;
      end
    end else begin
      wr1_en = we1 && (wa1 != '0);
      // Port 1 wins a same-address collision, so port 0 is dropped.
      wr0_en = we0 && (wa0 != '0) && !(wr1_en && (wa1 == wa0));
    end
    init_busy_d = (state_d == STATE_INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Array is deliberately not reset; the INIT walk clears it.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[wr0_addr] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[wa1] <= wd1;
    end
  end

  function automatic logic [WIDTH-1:0] read_word(input logic [BANK_WIDTH-1:0] addr);
    logic [WIDTH-1:0] val;
    val = mem_q[addr];
`ifdef REGFILE_MP_BYPASS_EN
    if (state_q == STATE_RUN) begin
      if (wr1_en && (wa1 == addr)) begin
        val = wd1;
      end else if (wr0_en && (wr0_addr == addr)) begin
        val = wr0_data;
      end
    end
`endif
    if (addr == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd[i*WIDTH +: WIDTH] = read_word(ra[i*BANK_WIDTH +: BANK_WIDTH]);
    end
    rd_db = read_word(ra_db);
  end

  assign init_busy = init_busy_q;

endmodule
